// File: rtl/risc_fetch_pkg.sv
// Shared types and helpers for the KGP-RISC decoupled instruction-fetch stage.
package risc_fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; pointers carry an extra MSB to tell full from empty.
module fetch_fifo
  import risc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned AW = clog2(DEPTH),
  localparam int unsigned CW = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  input  logic          flush,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = AW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ptr_diff;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign ptr_diff = wr_ptr - rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(ptr_diff);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Flush dominates push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/risc_fetch_unit.sv
// Decoupled fetch: credit-limited request/grant port, prefetch queue, redirect with
// discard of in-flight responses.
module risc_fetch_unit
  import risc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned CW = clog2(DEPTH + 1);
  // Headroom for stale responses accumulated over back-to-back redirects.
  localparam int unsigned DW = CW + 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic              req_en;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] resp_pc, resp_pc_nxt;
  logic [CW-1:0]     outstanding, outstanding_nxt;
  logic [DW-1:0]     discard, discard_nxt;

  logic              grant_hs;
  logic              keep_resp;
  logic              drop_resp;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_sum;
  entry_t            wdata;
  entry_t            head;

  // Request depends only on registers: queue occupancy plus kept in-flight fetches.
  assign credit_sum = (CW + 1)'(count) + (CW + 1)'(outstanding);
  assign imem_req   = req_en && (credit_sum < (CW + 1)'(DEPTH));
  assign imem_addr  = fetch_pc;

  assign grant_hs  = imem_req && imem_gnt;
  assign drop_resp = imem_rvalid && (discard != '0);
  assign keep_resp = imem_rvalid && (discard == '0);
  assign push      = keep_resp && !redirect_valid;
  assign pop       = instr_valid && instr_ready;
  assign wdata     = '{pc: resp_pc, instr: imem_rdata};

  assign instr_valid = !empty;
  assign instr_out   = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // On redirect every kept in-flight fetch, plus this cycle's grant, becomes stale.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    if (redirect_valid) begin
      fetch_pc_nxt    = redirect_pc;
      resp_pc_nxt     = redirect_pc;
      outstanding_nxt = '0;
      discard_nxt     = discard + DW'(outstanding) + DW'(grant_hs) - DW'(imem_rvalid);
    end else begin
      if (grant_hs)  fetch_pc_nxt = fetch_pc + ADDR_W'(1);
      if (keep_resp) resp_pc_nxt  = resp_pc + ADDR_W'(1);
      if (drop_resp) discard_nxt  = discard - DW'(1);
      outstanding_nxt = outstanding + CW'(grant_hs) - CW'(keep_resp);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_en      <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      req_en      <= 1'b1;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule
